skew_delay_line: RTL and testbench

Parametrised per-lane skew/deskew delay line for the systolic-array datapath: lane r of a SA_SIZE-wide vector is delayed by a lane-dependent number of stream advances, with a per-stage valid bit. SKEW_DIR selects ascending skew, for staggering activations into the array, or descending skew, for realigning array outputs. A self-timed flush state machine drains the line with zeros and signals completion. It sits between the activation/result buffers and the array edges and is stepped by the GEMM command bus.

---
 rtl/GEMM_pkg.sv | 28 ++
 rtl/skew_delay_line_lane.sv | 40 ++++
 rtl/skew_delay_line.sv | 94 +++++++++
 tb/tb_skew_delay_line.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/GEMM_pkg.sv
// Shared GEMM datapath types: command bus encoding, skew direction and flush FSM states.
package GEMM_pkg;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_STREAM = 2'd1,
        CMD_LOAD   = 2'd2,
        CMD_DRAIN  = 2'd3
    } command_t;

    typedef enum logic {
        SKEW_ASC  = 1'b0,
        SKEW_DESC = 1'b1
    } skew_dir_t;

    typedef enum logic {
        FLUSH_IDLE = 1'b0,
        FLUSH_RUN  = 1'b1
    } flush_state_t;

    // Skew in advances for one lane; ascending staggers inputs, descending realigns outputs.
    function automatic int unsigned lane_skew(input int unsigned sa_size,
                                              input int unsigned dir,
                                              input int unsigned lane);
        return (dir == 32'(SKEW_DESC)) ? (sa_size - 1 - lane) : lane;
    endfunction

endpackage

// File: rtl/skew_delay_line_lane.sv
// One lane of the skew line: DEPTH data/valid stages that shift together on advance.
module skew_lane #(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    input  logic                  zero_fill,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  any_valid
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (advance) begin
            data_q[0]  <= zero_fill ? '0 : in_data;
            valid_q[0] <= zero_fill ? 1'b0 : in_valid;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/skew_delay_line.sv
// Per-lane skew/deskew delay line with a self-timed zero-fill flush sequencer.
module skew_delay_line
    import GEMM_pkg::*;
#(
    parameter int unsigned SA_SIZE       = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SKEW_DIR      = 0,
    parameter int unsigned EXTRA_LATENCY = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  command_t                            cmd,
    input  logic [SA_SIZE-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic                                in_valid,
    input  logic                                flush_req,
    output logic [SA_SIZE-1:0][DATA_WIDTH-1:0]  out_data,
    output logic [SA_SIZE-1:0]                  out_valid,
    output logic                                busy,
    output logic                                flush_done
);

    localparam int unsigned D_MAX = SA_SIZE + EXTRA_LATENCY;
    localparam int unsigned CNT_W = $clog2(D_MAX + 1);

    flush_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             advance, zero_fill;
    logic [SA_SIZE-1:0] lane_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FLUSH_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // A stream command in the same cycle as flush_req still captures; flushing starts next cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        advance   = 1'b0;
        zero_fill = 1'b0;
        case (state_q)
            FLUSH_IDLE: begin
                advance = (cmd == CMD_STREAM);
                if (flush_req) begin
                    state_d = FLUSH_RUN;
                    cnt_d   = CNT_W'(D_MAX);
                end
            end
            FLUSH_RUN: begin
                advance   = 1'b1;
                zero_fill = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FLUSH_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = FLUSH_IDLE;
        endcase
    end

    for (genvar r = 0; r < SA_SIZE; r++) begin : g_lane
        localparam int unsigned DEPTH =
            lane_skew(SA_SIZE, SKEW_DIR, r) + 1 + EXTRA_LATENCY;

        skew_lane #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .advance   (advance),
            .zero_fill (zero_fill),
            .in_data   (in_data[r]),
            .in_valid  (in_valid),
            .out_data  (out_data[r]),
            .out_valid (out_valid[r]),
            .any_valid (lane_busy[r])
        );
    end

    assign busy       = (state_q == FLUSH_RUN) | (|lane_busy);
    assign flush_done = done_q;

endmodule

// File: tb/tb_skew_delay_line.sv
// Bench for skew_delay_line: ascending, descending (chained) and extra-latency instances.
module tb_skew_delay_line;
    import GEMM_pkg::*;

    localparam int SA = 4;
    localparam int DW = 8;

    typedef logic [SA-1:0][DW-1:0] vec_t;
    typedef struct packed { logic [DW-1:0] data; logic valid; } ent_t;
    typedef struct { logic in_valid; logic [SA-1:0] exp_valid; logic desc_chk; } row_t;

    logic     clk = 1'b0;
    logic     reset;
    command_t cmd;
    vec_t     in_data;
    logic     in_valid;
    logic     flush_req;

    vec_t           od [3];
    logic [SA-1:0]  ov [3];
    logic           bz [3];
    logic           fd [3];
    logic           chain_valid;

    int n_checks = 0;
    int n_errors = 0;

    ent_t        sb [2*SA][$];
    logic        m_flush [2];
    int unsigned m_cnt [2];
    logic        m_done [2];
    row_t        rows [8];

    always #5 clk = ~clk;

    assign chain_valid = |ov[0];

    // dut0: ascending, dut1: descending fed by dut0 (deskew), dut2: ascending with 2 extra stages
    skew_delay_line #(.SA_SIZE(SA), .DATA_WIDTH(DW), .SKEW_DIR(0), .EXTRA_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .cmd(cmd), .in_data(in_data), .in_valid(in_valid),
        .flush_req(flush_req), .out_data(od[0]), .out_valid(ov[0]), .busy(bz[0]),
        .flush_done(fd[0]));

    skew_delay_line #(.SA_SIZE(SA), .DATA_WIDTH(DW), .SKEW_DIR(1), .EXTRA_LATENCY(0)) dut1 (
        .clk(clk), .reset(reset), .cmd(cmd), .in_data(od[0]), .in_valid(chain_valid),
        .flush_req(flush_req), .out_data(od[1]), .out_valid(ov[1]), .busy(bz[1]),
        .flush_done(fd[1]));

    skew_delay_line #(.SA_SIZE(SA), .DATA_WIDTH(DW), .SKEW_DIR(0), .EXTRA_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .cmd(cmd), .in_data(in_data), .in_valid(in_valid),
        .flush_req(flush_req), .out_data(od[2]), .out_valid(ov[2]), .busy(bz[2]),
        .flush_done(fd[2]));

    function automatic int tb_depth(input int m, input int r);
        return r + 1 + ((m == 0) ? 0 : 2);
    endfunction

    function automatic int tb_dmax(input int m);
        return SA + ((m == 0) ? 0 : 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_flush[m] = 1'b0;
            m_cnt[m]   = 0;
            m_done[m]  = 1'b0;
            for (int r = 0; r < SA; r++) begin
                sb[m*SA+r].delete();
                for (int d = 0; d < tb_depth(m, r); d++) sb[m*SA+r].push_back('0);
            end
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            logic adv, zero;
            ent_t e;
            adv  = m_flush[m] || (cmd == CMD_STREAM);
            zero = m_flush[m];
            m_done[m] = 1'b0;
            if (m_flush[m]) begin
                m_cnt[m]--;
                if (m_cnt[m] == 0) begin
                    m_flush[m] = 1'b0;
                    m_done[m]  = 1'b1;
                end
            end else if (flush_req) begin
                m_flush[m] = 1'b1;
                m_cnt[m]   = tb_dmax(m);
            end
            if (adv) begin
                for (int r = 0; r < SA; r++) begin
                    if (zero) e = '0;
                    else begin
                        e.data  = in_data[r];
                        e.valid = in_valid;
                    end
                    sb[m*SA+r].push_back(e);
                    void'(sb[m*SA+r].pop_front());
                end
            end
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            int            d;
            vec_t          ev;
            logic [SA-1:0] evl;
            logic          eb;
            d  = (m == 0) ? 0 : 2;
            eb = m_flush[m];
            for (int r = 0; r < SA; r++) begin
                ev[r]  = sb[m*SA+r][0].data;
                evl[r] = sb[m*SA+r][0].valid;
                foreach (sb[m*SA+r][j]) eb |= sb[m*SA+r][j].valid;
            end
            chk($sformatf("dut%0d out_data", d), 64'(od[d]), 64'(ev));
            chk($sformatf("dut%0d out_valid", d), 64'(ov[d]), 64'(evl));
            chk($sformatf("dut%0d busy", d), 64'(bz[d]), 64'(eb));
            chk($sformatf("dut%0d flush_done", d), 64'(fd[d]), 64'(m_done[m]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input command_t c, input logic v, input vec_t data, input logic fr);
        cmd       = c;
        in_valid  = v;
        in_data   = data;
        flush_req = fr;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int r = 0; r < SA; r++) v[r] = DW'($urandom);
        return v;
    endfunction

    task automatic run_table();
        for (int i = 0; i < 8; i++) begin
            vec_t din, ev, ed;
            for (int r = 0; r < SA; r++) begin
                din[r] = rows[i].in_valid ? DW'(16*i + r) : '0;
                ev[r]  = rows[i].exp_valid[r] ? DW'(16*(i-r) + r) : '0;
                ed[r]  = DW'(16*(i-4) + r);
            end
            drive(CMD_STREAM, rows[i].in_valid, din, 1'b0);
            tick();
            chk($sformatf("table row%0d data", i), 64'(od[0]), 64'(ev));
            chk($sformatf("table row%0d valid", i), 64'(ov[0]), 64'(rows[i].exp_valid));
            if (rows[i].desc_chk) begin
                chk($sformatf("deskew row%0d data", i), 64'(od[1]), 64'(ed));
                chk($sformatf("deskew row%0d valid", i), 64'(ov[1]), 64'(4'hF));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s dut%0d out_data", tag, d), 64'(od[d]), 64'(0));
            chk($sformatf("%s dut%0d out_valid", tag, d), 64'(ov[d]), 64'(0));
            chk($sformatf("%s dut%0d busy", tag, d), 64'(bz[d]), 64'(0));
            chk($sformatf("%s dut%0d flush_done", tag, d), 64'(fd[d]), 64'(0));
        end
    endtask

    initial begin
        int   done0, done2;
        vec_t va, vb;

        rows[0] = '{1'b1, 4'b0001, 1'b0};
        rows[1] = '{1'b1, 4'b0011, 1'b0};
        rows[2] = '{1'b1, 4'b0111, 1'b0};
        rows[3] = '{1'b1, 4'b1111, 1'b0};
        rows[4] = '{1'b0, 4'b1110, 1'b1};
        rows[5] = '{1'b0, 4'b1100, 1'b1};
        rows[6] = '{1'b0, 4'b1000, 1'b1};
        rows[7] = '{1'b0, 4'b0000, 1'b1};

        reset = 1'b1;
        drive(CMD_NOP, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Staggered stream with trailing empty advances; dut1 realigns dut0's output.
        run_table();

        // Hold for 3 cycles mid-stream with non-stream commands and changing inputs.
        for (int r = 0; r < SA; r++) begin
            va[r] = DW'(8'hA0 + r);
            vb[r] = DW'(8'hB0 + r);
        end
        drive(CMD_STREAM, 1'b1, va, 1'b0); tick();
        drive(CMD_STREAM, 1'b1, vb, 1'b0); tick();
        for (int h = 0; h < 3; h++) begin
            drive((h == 1) ? CMD_LOAD : CMD_NOP, 1'b1, rand_vec(), 1'b0);
            tick();
            chk($sformatf("hold%0d data", h), 64'(od[0]), 64'(32'h0000A1B0));
            chk($sformatf("hold%0d valid", h), 64'(ov[0]), 64'(4'b0011));
        end
        for (int s = 0; s < 6; s++) begin
            drive(CMD_STREAM, 1'b0, '0, 1'b0);
            tick();
        end

        // Flush with cmd held at stream; a second flush_req mid-flush must be ignored.
        drive(CMD_STREAM, 1'b1, rand_vec(), 1'b0); tick();
        drive(CMD_STREAM, 1'b1, rand_vec(), 1'b1); tick();
        done0 = -1;
        done2 = -1;
        for (int t = 1; t <= 10; t++) begin
            drive(CMD_STREAM, 1'b1, rand_vec(), (t == 2));
            tick();
            if (fd[0] === 1'b1 && done0 < 0) begin
                done0 = t;
                chk("flush dut0 busy at done", 64'(bz[0]), 64'(0));
                chk("flush dut0 valid at done", 64'(ov[0]), 64'(0));
            end
            if (fd[2] === 1'b1 && done2 < 0) begin
                done2 = t;
                chk("flush dut2 busy at done", 64'(bz[2]), 64'(0));
                chk("flush dut2 valid at done", 64'(ov[2]), 64'(0));
            end
        end
        chk("flush dut0 length", 64'(done0), 64'(4));
        chk("flush dut2 length", 64'(done2), 64'(6));
        for (int s = 0; s < 8; s++) begin
            drive(CMD_NOP, 1'b0, '0, 1'b0);
            tick();
        end

        // Asynchronous reset in the second flush cycle, then a fresh stream.
        drive(CMD_STREAM, 1'b1, rand_vec(), 1'b0); tick();
        drive(CMD_STREAM, 1'b1, rand_vec(), 1'b1); tick();
        drive(CMD_NOP, 1'b0, '0, 1'b0); tick();
        chk("pre-reset dut0 busy", 64'(bz[0]), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check_all_zero("post reset");
        run_table();

        drive(CMD_NOP, 1'b0, '0, 1'b1); tick();
        drive(CMD_NOP, 1'b0, '0, 1'b0);
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
